gray_counter: RTL
=================

# gray_counter

Parametrised Gray-code counter: the successor to the fixed free-running Gray generator. Adds enable, up/down direction, synchronous load, wrap-or-saturate end behaviour, a registered binary mirror of the count and a terminal-count pulse. Intended as the pointer source for async-FIFO and position-encoder logic. Each step changes exactly one output bit, except a synchronous load.

## Interface
- DATA_WIDTH, 4: counter width in bits; legal range ≥ 2.
- SATURATE, 0: 0 = wrap at either end; 1 = hold at the end value.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement (binary sense).
- load  input  1  synchronous load strobe.
- load_val  input  DATA_WIDTH  binary value to load.
- out  output  DATA_WIDTH  registered Gray-coded count.
- bin  output  DATA_WIDTH  registered binary count; always equals Gray-to-binary of `out`.
- wrap  output  1  one-cycle pulse, registered; see Operation.

## Operation
- Internal state is a binary register `b`.
- `out = b ^ (b >> 1)` is computed into a register, not driven combinationally from `b`.
- Per-edge priority: reset > load > en > hold.
- **load = 1**
  - `b` takes `load_val`; `en` and `up` are ignored that cycle.
  - `wrap` is 0.
  - `out` may change more than one bit on a load.
- **en = 1, load = 0, up = 1**
  - Below max (2^DATA_WIDTH−1): `b` increments by 1.
  - At max with SATURATE = 0: `b` becomes 0 and `wrap` pulses 1.
  - At max with SATURATE = 1: `b` holds and `wrap` = 0.
- **en = 1, load = 0, up = 0**
  - Above 0: `b` decrements by 1.
  - At 0 with SATURATE = 0: `b` becomes max and `wrap` pulses 1.
  - At 0 with SATURATE = 1: `b` holds and `wrap` = 0.
- **en = 0, load = 0**: `b`, `out` and `bin` hold; `wrap` = 0.
- Direction may change on any cycle. The next step uses the new `up` with no penalty cycle.
- Arithmetic is modulo 2^DATA_WIDTH. No intermediate wider than DATA_WIDTH+1 bits.
- The block has no state machine beyond the counter register itself. No output depends combinationally on any input.

## Timing
- Reset values: `out` = 0, `bin` = 0, `wrap` = 0.
- Reset asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.
- After reset deasserts, the first rising edge with `en` = 1 produces `out` = 1 (up) or `out` = Gray(max) (down).
- Latency: inputs sampled at edge N appear on `out`, `bin` and `wrap` after edge N. This is one register stage.
- `out` and `bin` are updated on the same edge and are always mutually consistent.
- `wrap` is high for exactly one cycle per wrap event.
  - It stays high on consecutive cycles only if consecutive wraps occur.
  - With DATA_WIDTH ≥ 2 that can only happen through a direction toggle at an end value, e.g. up at max then down at 0.
- Simultaneous `load` and `en`: load wins and no step is taken.
- Loading the current value is legal; outputs are unchanged and `wrap` = 0.

## Test plan
- **Reset, free-run up.** Reset high 2 cycles, then `en` = 1, `up` = 1, DATA_WIDTH = 4, SATURATE = 0, for 17 cycles.
  - `out` = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1.
  - `wrap` = 1 only on the cycle `out` returns to 0.
  - Checker confirms exactly one bit changes per step.
- **Down count and wrap.** From reset, `en` = 1, `up` = 0.
  - `out` = 8,9,B,A… and `bin` = F,E,D…
  - `wrap` pulses on the first step, 0→F.
- **Load priority.** At `bin` = 5, assert `load` = 1, `load_val` = A, `en` = 1.
  - Next cycle `bin` = A, `out` = F, `wrap` = 0.
  - Counting then resumes: `bin` = B, `out` = E.
- **Saturate mode.** With SATURATE = 1, load E, count up 3 cycles.
  - `bin` = F, F, F; `out` = 8 held; `wrap` never asserts.
  - Same check downward from 1: `bin` holds at 0.
- **Enable gating and direction flip.** Toggle `en` every cycle; `bin` advances only on enabled cycles.
  - At `bin` = 0 with SATURATE = 0: `up` = 1 gives `bin` = 1; flipping `up` = 0 next cycle returns `bin` to 0.
- **Async reset mid-count.** At `bin` = 9, assert `reset` between clock edges.
  - `out`, `bin` and `wrap` read 0 before the next rising edge.
  - After release, counting restarts from 0.

Source files
------------

// File: rtl/gray_counter.sv
// gray_counter: binary-state Gray counter with enable, up/down, synchronous load,
// wrap-or-saturate ends, a registered binary mirror and a terminal-count pulse.
// Each step changes a single bit of out. A load can change several bits.
module gray_counter #(
  parameter int DATA_WIDTH = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] bin,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] MAXV = '1;
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] b;
    logic                  wrap;
  } nxt_t;

  logic [DATA_WIDTH-1:0] b;
  nxt_t                  nxt;

  // next binary state and wrap flag; priority is load > en > hold
  always_comb begin
    nxt.b    = b;
    nxt.wrap = 1'b0;
    if (load) begin
      nxt.b = load_val;
    end else if (en) begin
      if (up) begin
        if (b != MAXV)     nxt.b = b + ONE;
        else if (!SATURATE) begin
          nxt.b    = '0;
          nxt.wrap = 1'b1;
        end
      end else begin
        if (b != '0)       nxt.b = b - ONE;
        else if (!SATURATE) begin
          nxt.b    = MAXV;
          nxt.wrap = 1'b1;
        end
      end
    end
  end

  // binary and Gray images are registered from the same next value, so they always agree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b    <= '0;
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      b    <= nxt.b;
      out  <= nxt.b ^ (nxt.b >> 1);
      wrap <= nxt.wrap;
    end
  end

  assign bin = b;

endmodule
